// File: rtl/irq_request_latch.sv
// Interrupt request front-end: rising-edge capture into sticky pending bits, masking, and a
// registered one-hot grant with valid/ack handshake toward the priority encoder.
module irq_request_latch #(
   parameter int unsigned N   = 8,
   parameter int unsigned GAP = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   input  logic [N-1:0] mask,
   output logic [N-1:0] sel,
   output logic         grant_vld,
   input  logic         grant_ack,
   output logic [N-1:0] pending,
   output logic [N-1:0] ovf,
   input  logic         ovf_clr
);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   localparam logic [1:0] GapLoad = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

   logic [N-1:0] req_q;
   logic [N-1:0] pending_q, pending_d;
   logic [N-1:0] ovf_q, ovf_d;
   logic [N-1:0] sel_q, sel_d;
   logic         grant_vld_q, grant_vld_d;
   state_e       state_q, state_d;
   logic [1:0]   gap_cnt_q, gap_cnt_d;

   logic [N-1:0] rise, clr, elig, pick;

   always_comb begin
      rise = req_in & ~req_q;
      clr  = (grant_vld_q && grant_ack) ? sel_q : '0;
      // A new edge beats a same-cycle clear, so the bit remains pending.
      pending_d = (pending_q & ~clr) | rise;
      ovf_d     = (ovf_clr ? '0 : ovf_q) | (rise & pending_q & ~clr);
      elig      = pending_q & ~mask;

      // Ascending scan: the last hit is the highest-priority line.
      pick = '0;
      for (int i = 0; i < N; i++) begin
         if (elig[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      grant_vld_d = grant_vld_q;
      gap_cnt_d   = gap_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (|elig) begin
               sel_d       = pick;
               grant_vld_d = 1'b1;
               state_d     = StGrant;
            end
         end
         StGrant: begin
            if (grant_ack) begin
               sel_d       = '0;
               grant_vld_d = 1'b0;
               if (GAP > 0) begin
                  state_d   = StGap;
                  gap_cnt_d = GapLoad;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StGap: begin
            // The final gap cycle re-evaluates selection so the next grant lands right after it.
            if (gap_cnt_q != 2'd0) begin
               gap_cnt_d = gap_cnt_q - 2'd1;
            end else if (|elig) begin
               sel_d       = pick;
               grant_vld_d = 1'b1;
               state_d     = StGrant;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q       <= req_in;
         pending_q   <= '0;
         ovf_q       <= '0;
         sel_q       <= '0;
         grant_vld_q <= 1'b0;
         state_q     <= StIdle;
         gap_cnt_q   <= 2'd0;
      end else begin
         req_q       <= req_in;
         pending_q   <= pending_d;
         ovf_q       <= ovf_d;
         sel_q       <= sel_d;
         grant_vld_q <= grant_vld_d;
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign sel       = sel_q;
   assign grant_vld = grant_vld_q;
   assign pending   = pending_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: a vector table for the basic flows, then hand-written
// sequences for masking, overflow, ack/edge collision and mid-grant reset.
module tb_irq_request_latch;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_in, mask, sel, pending, ovf;
   logic       grant_vld, grant_ack, ovf_clr;

   int n_checks = 0;
   int n_pass   = 0;

   irq_request_latch #(.N(8), .GAP(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .mask      (mask),
      .sel       (sel),
      .grant_vld (grant_vld),
      .grant_ack (grant_ack),
      .pending   (pending),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] mask;
      logic       ack;
      logic       oclr;
      logic [7:0] e_pend;
      logic [7:0] e_sel;
      logic       e_vld;
      logic [7:0] e_ovf;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(logic r, logic [7:0] q, logic [7:0] m, logic a, logic oc,
                               logic [7:0] ep, logic [7:0] es, logic ev, logic [7:0] eo);
      vec_t v;
      v.rst = r; v.req = q; v.mask = m; v.ack = a; v.oclr = oc;
      v.e_pend = ep; v.e_sel = es; v.e_vld = ev; v.e_ovf = eo;
      return v;
   endfunction

   task automatic check(string name, logic [7:0] got, logic [7:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %02h want %02h", name, got, want);
   endtask

   task automatic check_all(string tag, logic [7:0] ep, logic [7:0] es, logic ev,
                            logic [7:0] eo);
      check({tag, ".pending"}, pending, ep);
      check({tag, ".sel"}, sel, es);
      check({tag, ".grant_vld"}, {7'd0, grant_vld}, {7'd0, ev});
      check({tag, ".ovf"}, ovf, eo);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic r, logic [7:0] q, logic [7:0] m, logic a, logic oc);
      rst = r; req_in = q; mask = m; grant_ack = a; ovf_clr = oc;
   endtask

   initial begin
      //              rst req    mask   ack oclr pend   sel    vld ovf
      vecs[0]  = mk(1, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[1]  = mk(1, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[2]  = mk(0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[3]  = mk(0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[4]  = mk(0, 8'h09, 8'h00, 0, 0, 8'h08, 8'h00, 0, 8'h00);
      vecs[5]  = mk(0, 8'h01, 8'h00, 0, 0, 8'h08, 8'h08, 1, 8'h00);
      vecs[6]  = mk(0, 8'h01, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[7]  = mk(0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[8]  = mk(0, 8'h43, 8'h00, 0, 0, 8'h42, 8'h00, 0, 8'h00);
      vecs[9]  = mk(0, 8'h01, 8'h00, 0, 0, 8'h42, 8'h40, 1, 8'h00);
      vecs[10] = mk(0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 8'h00);
      vecs[11] = mk(0, 8'h01, 8'h00, 0, 0, 8'h02, 8'h02, 1, 8'h00);
      vecs[12] = mk(0, 8'h01, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[13] = mk(0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[14] = mk(0, 8'h01, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00);

      drive(1, 8'h01, 8'h00, 0, 0);
      step();
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].mask, vecs[i].ack, vecs[i].oclr);
         step();
         check_all($sformatf("v%0d", i), vecs[i].e_pend, vecs[i].e_sel, vecs[i].e_vld,
                   vecs[i].e_ovf);
      end

      // Masked higher line; unmasking mid-grant must not disturb the grant.
      drive(0, 8'h43, 8'h40, 0, 0); step(); check_all("m0", 8'h42, 8'h00, 0, 8'h00);
      drive(0, 8'h01, 8'h40, 0, 0); step(); check_all("m1", 8'h42, 8'h02, 1, 8'h00);
      drive(0, 8'h01, 8'h00, 0, 0); step(); check_all("m2", 8'h42, 8'h02, 1, 8'h00);
      step();                               check_all("m3", 8'h42, 8'h02, 1, 8'h00);
      drive(0, 8'h01, 8'h00, 1, 0); step(); check_all("m4", 8'h40, 8'h00, 0, 8'h00);
      drive(0, 8'h01, 8'h00, 0, 0); step(); check_all("m5", 8'h40, 8'h40, 1, 8'h00);
      drive(0, 8'h01, 8'h00, 1, 0); step(); check_all("m6", 8'h00, 8'h00, 0, 8'h00);
      drive(0, 8'h01, 8'h00, 0, 0); step(); check_all("m7", 8'h00, 8'h00, 0, 8'h00);

      // Overflow on re-edge, edge colliding with ack, ovf set beating ovf_clr.
      drive(0, 8'h05, 8'h00, 0, 0); step(); check_all("o0", 8'h04, 8'h00, 0, 8'h00);
      drive(0, 8'h01, 8'h00, 0, 0); step(); check_all("o1", 8'h04, 8'h04, 1, 8'h00);
      drive(0, 8'h05, 8'h00, 0, 0); step(); check_all("o2", 8'h04, 8'h04, 1, 8'h04);
      drive(0, 8'h01, 8'h00, 0, 0); step(); check_all("o3", 8'h04, 8'h04, 1, 8'h04);
      drive(0, 8'h05, 8'h00, 1, 0); step(); check_all("o4", 8'h04, 8'h00, 0, 8'h04);
      drive(0, 8'h01, 8'h00, 0, 0); step(); check_all("o5", 8'h04, 8'h04, 1, 8'h04);
      drive(0, 8'h01, 8'h00, 0, 1); step(); check_all("o6", 8'h04, 8'h04, 1, 8'h00);
      drive(0, 8'h05, 8'h00, 0, 1); step(); check_all("o7", 8'h04, 8'h04, 1, 8'h04);

      // Reset while a grant is outstanding.
      drive(1, 8'h01, 8'h00, 0, 0); step(); check_all("r0", 8'h00, 8'h00, 0, 8'h00);
      drive(0, 8'h01, 8'h00, 0, 0); step(); check_all("r1", 8'h00, 8'h00, 0, 8'h00);
      step();                               check_all("r2", 8'h00, 8'h00, 0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
